mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the cache-to-memory request interface; it is the target end of the protocol the data cache initiates.
- Accepts read and write requests over a 128-bit beat interface.
- Reads return a 4-beat line burst after a configurable latency. Writes accept one masked data beat per request.
- Backed by an internal behavioural array; used as the memory model under the cache in unit and system benches.

Parameters:
- ADDR_BITS, 28, width of mem_req_addr; addresses are in 128-bit beat units.
- DATA_BITS, 128, beat width; mask width is DATA_BITS/8.
- DEPTH_LOG2, 12, array holds 2^DEPTH_LOG2 beats; only addr[DEPTH_LOG2-1:0] is used, upper bits alias.
- READ_LATENCY, 4, cycles from read accept to first response beat; legal range 1..15.
- BURST_BEATS, 4, beats per read burst; power of two.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mem_req_valid  in  1  request valid.
- mem_req_ready  out  1  request ready.
- mem_req_addr  in  ADDR_BITS  beat address.
- mem_req_rw  in  1  0 = read, 1 = write.
- mem_req_data_valid  in  1  write data valid.
- mem_req_data_ready  out  1  write data ready.
- mem_req_data_bits  in  DATA_BITS  write data.
- mem_req_data_mask  in  DATA_BITS/8  byte enables; bit i covers data[8i+7:8i].
- mem_resp_valid  out  1  read beat valid.
- mem_resp_data  out  DATA_BITS  read beat data.

Behaviour:
- Reset and outputs:
  - Reset is synchronous, active-high, on clk.
  - While reset is high, all outputs are 0 and the state goes to IDLE.
  - Array contents are not cleared by reset. Power-up contents are X unless preloaded by the bench.
  - mem_req_ready is 1 in the first cycle after reset deasserts.
- Outputs decode from state; ready signals do not depend on the matching valid. The initiator samples ready before asserting valid.
- States: IDLE, RLAT, RBURST, WDATA.
- IDLE:
  - mem_req_ready=1, mem_req_data_ready=0, mem_resp_valid=0.
  - On mem_req_valid&&mem_req_ready: latch addr and rw.
  - rw=0: go to RLAT with lat_cnt=READ_LATENCY-1, or straight to RBURST when READ_LATENCY=1.
  - rw=1: go to WDATA.
  - mem_req_data_valid in IDLE is ignored.
- RLAT: all readies 0; decrement lat_cnt; at 0, go to RBURST with beat=0.
- RBURST:
  - mem_resp_valid=1 for exactly BURST_BEATS consecutive cycles. No backpressure.
  - Beat k returns mem[{addr[DEPTH_LOG2-1:log2(BURST_BEATS)], k}], i.e. the burst starts at the aligned line base regardless of the low address bits. Order is 0,1,2,3.
  - First beat appears exactly READ_LATENCY cycles after the accept edge.
  - After the last beat, go to IDLE; mem_req_ready=1 the following cycle.
  - mem_resp_data is 0 whenever mem_resp_valid=0.
- WDATA:
  - mem_req_data_ready=1, mem_req_ready=0.
  - On data fire: bytes with mask=1 are written to mem[addr] (unaligned, exact beat); bytes with mask=0 are unchanged; go to IDLE.
  - Waits indefinitely for data.
- Requests presented while not in IDLE are not accepted; mem_req_valid must be held by the initiator.
- A read of a beat written by an earlier request returns the new data; there is no hazard window.
- Reset mid-operation:
  - Abort immediately; no further beats are issued.
  - A WDATA write is committed only if data fired before the reset cycle.
  - Completed writes are retained.
- lat_cnt is 4 bits wide. beat is log2(BURST_BEATS) bits wide and wraps naturally; completion is detected at beat==BURST_BEATS-1.

Test Plan:
- Reset, then write addr 0x0000010, mask 0xFFFF, data 0x0123..CDEF; then read addr 0x0000010 accepted at cycle T -> mem_resp_valid high at T+4..T+7; beat0 = 0x0123..CDEF; mem_req_ready low T+1..T+7, high at T+8.
- Preload 0x0000020 = all 0xAA, write mask 0x000F with data all 0x55, read -> beat0 = 0xAAAA..AAAA_55555555.
- Preload beats 0x10..0x13 with values 1..4; read addr 0x0000013 -> beats return 1,2,3,4 in order.
- Hold mem_req_valid continuously with two back-to-back reads -> second accepted only in the IDLE cycle after the first burst; exactly 8 resp beats total, gap of READ_LATENCY+1 cycles between bursts.
- Assert reset for one cycle after beat1 of a burst -> mem_resp_valid=0 the next cycle, no further beats, mem_req_ready=1 after release; a re-read returns unchanged data.
- With DEPTH_LOG2=12: write 0x0001000, then read 0x0000000 -> beat0 equals the written data (aliasing).

Source files
------------

// File: rtl/mem_responder_if.sv
// Cache-to-memory bundle: request channel, write-data channel and read-beat return.
// The cache side is the master and the memory responder is the slave.
interface mem_responder_if #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128
);
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [ADDR_BITS-1:0]   mem_req_addr;
    logic                   mem_req_rw;
    logic                   mem_req_data_valid;
    logic                   mem_req_data_ready;
    logic [DATA_BITS-1:0]   mem_req_data_bits;
    logic [DATA_BITS/8-1:0] mem_req_data_mask;
    logic                   mem_resp_valid;
    logic [DATA_BITS-1:0]   mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_rw,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_rw,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request at a time, returns an aligned line burst
// after a fixed latency for reads, and commits one byte-masked beat for writes.
module mem_responder #(
    parameter int ADDR_BITS    = 28,
    parameter int DATA_BITS    = 128,
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 4,
    parameter int BURST_BEATS  = 4
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int BEAT_BITS = $clog2(BURST_BEATS);
    localparam int MASK_BITS = DATA_BITS / 8;
    localparam logic [3:0]           LAT_INIT  = 4'(READ_LATENCY - 1);
    localparam logic [BEAT_BITS-1:0] BEAT_ONE  = BEAT_BITS'(1);
    localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(BURST_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RLAT,
        RBURST,
        WDATA
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DEPTH_LOG2-1:0]   r_addr;
    logic [DEPTH_LOG2-1:0]   w_addr_next;
    logic [3:0]              r_lat_cnt;
    logic [3:0]              w_lat_next;
    logic [BEAT_BITS-1:0]    r_beat;
    logic [BEAT_BITS-1:0]    w_beat_next;
    logic                    w_req_ready;
    logic                    w_data_ready;
    logic                    w_resp_valid;
    logic                    w_wr_fire;
    logic [DATA_BITS-1:0]    r_mem [2**DEPTH_LOG2];

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_lat_next   = r_lat_cnt;
        w_beat_next  = r_beat;
        w_req_ready  = 1'b0;
        w_data_ready = 1'b0;
        w_resp_valid = 1'b0;
        w_wr_fire    = 1'b0;

        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.mem_req_valid) begin
                    w_addr_next = bus.mem_req_addr[DEPTH_LOG2-1:0];
                    if (bus.mem_req_rw) begin
                        w_state_next = WDATA;
                    end else if (READ_LATENCY == 1) begin
                        w_state_next = RBURST;
                        w_beat_next  = '0;
                    end else begin
                        w_state_next = RLAT;
                        w_lat_next   = LAT_INIT;
                    end
                end
            end
            RLAT: begin
                if (r_lat_cnt == 4'd0) begin
                    w_state_next = RBURST;
                    w_beat_next  = '0;
                end else begin
                    w_lat_next = r_lat_cnt - 4'd1;
                end
            end
            RBURST: begin
                w_resp_valid = 1'b1;
                w_beat_next  = r_beat + BEAT_ONE;
                if (r_beat == BEAT_LAST) begin
                    w_state_next = IDLE;
                end
            end
            WDATA: begin
                w_data_ready = 1'b1;
                if (bus.mem_req_data_valid) begin
                    w_wr_fire    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Reset silences every output in the same cycle, so nothing fires or issues under it.
        if (reset) begin
            w_req_ready  = 1'b0;
            w_data_ready = 1'b0;
            w_resp_valid = 1'b0;
            w_wr_fire    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_lat_cnt <= '0;
            r_beat    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_addr    <= w_addr_next;
            r_lat_cnt <= w_lat_next;
            r_beat    <= w_beat_next;
        end
    end

    // NOTE: the array has no reset; completed writes must survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (bus.mem_req_data_mask[i]) begin
                    r_mem[r_addr][8*i +: 8] <= bus.mem_req_data_bits[8*i +: 8];
                end
            end
        end
    end

    assign bus.mem_req_ready      = w_req_ready;
    assign bus.mem_req_data_ready = w_data_ready;
    assign bus.mem_resp_valid     = w_resp_valid;
    assign bus.mem_resp_data      = w_resp_valid
                                  ? r_mem[{r_addr[DEPTH_LOG2-1:BEAT_BITS], r_beat}]
                                  : '0;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: read timing, masked writes, burst order,
// back-to-back requests, reset abort and address aliasing.
module tb_mem_responder;
    localparam int ADDR_BITS    = 28;
    localparam int DATA_BITS    = 128;
    localparam int DEPTH_LOG2   = 12;
    localparam int READ_LATENCY = 4;
    localparam int BURST_BEATS  = 4;
    localparam int OBS_CYCLES   = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic                 obs_valid [OBS_CYCLES];
    logic                 obs_ready [OBS_CYCLES];
    logic [DATA_BITS-1:0] obs_data  [OBS_CYCLES];
    logic [DATA_BITS-1:0] got       [BURST_BEATS];
    int                   got_n;
    int                   got_first;

    mem_responder_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) bus ();

    mem_responder #(
        .ADDR_BITS   (ADDR_BITS),
        .DATA_BITS   (DATA_BITS),
        .DEPTH_LOG2  (DEPTH_LOG2),
        .READ_LATENCY(READ_LATENCY),
        .BURST_BEATS (BURST_BEATS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_req_valid      = 1'b0;
        bus.mem_req_addr       = '0;
        bus.mem_req_rw         = 1'b0;
        bus.mem_req_data_valid = 1'b0;
        bus.mem_req_data_bits  = '0;
        bus.mem_req_data_mask  = '0;
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.mem_req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL ready_timeout: mem_req_ready stayed %b, required 1", bus.mem_req_ready);
        end
    endtask

    task automatic write_beat(input logic [ADDR_BITS-1:0] a, input logic [DATA_BITS-1:0] d,
                              input logic [DATA_BITS/8-1:0] m);
        bit ok = 1'b0;
        wait_ready();
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b1;
        bus.mem_req_addr  = a;
        tick();
        bus.mem_req_valid      = 1'b0;
        bus.mem_req_rw         = 1'b0;
        bus.mem_req_data_valid = 1'b1;
        bus.mem_req_data_bits  = d;
        bus.mem_req_data_mask  = m;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_req_data_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.mem_req_data_valid = 1'b0;
        bus.mem_req_data_bits  = '0;
        bus.mem_req_data_mask  = '0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL data_ready_timeout: addr %h write data never accepted, required accept", a);
        end
    endtask

    // Issues a read and records outputs at #1 after each edge k, where edge 0 is the accept edge.
    task automatic read_line(input logic [ADDR_BITS-1:0] a);
        wait_ready();
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = a;
        tick();
        bus.mem_req_valid = 1'b0;
        got_n     = 0;
        got_first = -1;
        for (int k = 0; k < OBS_CYCLES; k++) begin
            obs_valid[k] = bus.mem_resp_valid;
            obs_ready[k] = bus.mem_req_ready;
            obs_data[k]  = bus.mem_resp_data;
            if (bus.mem_resp_valid === 1'b1) begin
                if (got_n < BURST_BEATS) got[got_n] = bus.mem_resp_data;
                if (got_first < 0) got_first = k;
                got_n++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp += 4;
        if (bus.mem_req_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_req_ready: got %b expected 0", bus.mem_req_ready);
        end
        if (bus.mem_req_data_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_data_ready: got %b expected 0", bus.mem_req_data_ready);
        end
        if (bus.mem_resp_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_resp_valid: got %b expected 0", bus.mem_resp_valid);
        end
        if (bus.mem_resp_data !== '0) begin
            n_err++; $display("FAIL reset_resp_data: got %h expected 0", bus.mem_resp_data);
        end
        reset = 1'b0;
        #1;
        n_cmp += 2;
        if (bus.mem_req_ready !== 1'b1) begin
            n_err++; $display("FAIL release_req_ready: got %b expected 1", bus.mem_req_ready);
        end
        if (bus.mem_req_data_ready !== 1'b0) begin
            n_err++; $display("FAIL release_data_ready: got %b expected 0", bus.mem_req_data_ready);
        end
    endtask

    task automatic test_write_read();
        logic [DATA_BITS-1:0] d1 = 128'h0123456789ABCDEF_0123456789ABCDEF;
        write_beat(28'h0000010, d1, 16'hFFFF);
        read_line(28'h0000010);
        for (int k = 0; k <= 8; k++) begin
            logic exp_v = (k >= 4 && k <= 7);
            logic exp_r = (k == 8);
            n_cmp += 2;
            if (obs_valid[k] !== exp_v) begin
                n_err++; $display("FAIL wr_rd_resp_valid[k=%0d]: got %b expected %b", k, obs_valid[k], exp_v);
            end
            if (obs_ready[k] !== exp_r) begin
                n_err++; $display("FAIL wr_rd_req_ready[k=%0d]: got %b expected %b", k, obs_ready[k], exp_r);
            end
            if (!exp_v) begin
                n_cmp++;
                if (obs_data[k] !== '0) begin
                    n_err++; $display("FAIL wr_rd_idle_data[k=%0d]: got %h expected 0", k, obs_data[k]);
                end
            end
        end
        n_cmp += 2;
        if (got_n !== 4) begin
            n_err++; $display("FAIL wr_rd_beat_count: got %0d expected 4", got_n);
        end
        if (got[0] !== d1) begin
            n_err++; $display("FAIL wr_rd_beat0: got %h expected %h", got[0], d1);
        end
    endtask

    task automatic test_partial_mask();
        logic [DATA_BITS-1:0] exp0 = {{12{8'hAA}}, {4{8'h55}}};
        logic [DATA_BITS-1:0] exp1 = {8'h11, {15{8'h77}}};
        write_beat(28'h0000020, {16{8'hAA}}, 16'hFFFF);
        write_beat(28'h0000020, {16{8'h55}}, 16'h000F);
        write_beat(28'h0000021, {16{8'h77}}, 16'hFFFF);
        write_beat(28'h0000021, {16{8'h11}}, 16'h8000);
        read_line(28'h0000020);
        n_cmp += 2;
        if (got[0] !== exp0) begin
            n_err++; $display("FAIL mask_low_bytes: got %h expected %h", got[0], exp0);
        end
        if (got[1] !== exp1) begin
            n_err++; $display("FAIL mask_top_byte: got %h expected %h", got[1], exp1);
        end
    endtask

    task automatic test_burst_order();
        for (int i = 0; i < 4; i++) begin
            write_beat(28'h0000010 + 28'(i), 128'(i + 1), 16'hFFFF);
        end
        read_line(28'h0000013);
        n_cmp += 2;
        if (got_first !== 4) begin
            n_err++; $display("FAIL order_first_edge: got %0d expected 4", got_first);
        end
        if (got_n !== 4) begin
            n_err++; $display("FAIL order_beat_count: got %0d expected 4", got_n);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got[i] !== 128'(i + 1)) begin
                n_err++; $display("FAIL order_beat%0d: got %h expected %h", i, got[i], 128'(i + 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        int acc_edge [2] = '{-1, -1};
        int beats = 0;
        int beat_edge [8];
        logic [DATA_BITS-1:0] bdata [8];
        logic ready_before;
        wait_ready();
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = 28'h0000010;
        for (int e = 0; e < 30; e++) begin
            ready_before = bus.mem_req_ready;
            @(posedge clk);
            #1;
            if (ready_before === 1'b1 && bus.mem_req_valid === 1'b1) begin
                if (accepts < 2) acc_edge[accepts] = e;
                accepts++;
                if (accepts == 2) bus.mem_req_valid = 1'b0;
            end
            if (bus.mem_resp_valid === 1'b1) begin
                if (beats < 8) begin
                    beat_edge[beats] = e;
                    bdata[beats]     = bus.mem_resp_data;
                end
                beats++;
            end
        end
        bus.mem_req_valid = 1'b0;
        n_cmp += 3;
        if (accepts !== 2) begin
            n_err++; $display("FAIL b2b_accepts: got %0d expected 2", accepts);
        end
        if (acc_edge[1] !== 9) begin
            n_err++; $display("FAIL b2b_second_accept_edge: got %0d expected 9", acc_edge[1]);
        end
        if (beats !== 8) begin
            n_err++; $display("FAIL b2b_beat_total: got %0d expected 8", beats);
        end
        if (beats == 8) begin
            n_cmp += 4;
            if (beat_edge[0] !== 4) begin
                n_err++; $display("FAIL b2b_first_burst_edge: got %0d expected 4", beat_edge[0]);
            end
            if (beat_edge[4] - beat_edge[3] - 1 !== READ_LATENCY + 1) begin
                n_err++; $display("FAIL b2b_gap: got %0d expected %0d", beat_edge[4] - beat_edge[3] - 1, READ_LATENCY + 1);
            end
            if (bdata[4] !== 128'd1) begin
                n_err++; $display("FAIL b2b_second_beat0: got %h expected 1", bdata[4]);
            end
            if (bdata[7] !== 128'd4) begin
                n_err++; $display("FAIL b2b_second_beat3: got %h expected 4", bdata[7]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        wait_ready();
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = 28'h0000010;
        tick();
        bus.mem_req_valid = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (bus.mem_resp_data !== 128'd2) begin
            n_err++; $display("FAIL rst_mid_beat1: got %h expected 2", bus.mem_resp_data);
        end
        tick();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.mem_resp_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_valid_in_reset: got %b expected 0", bus.mem_resp_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp += 2;
        if (bus.mem_resp_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_valid_after: got %b expected 0", bus.mem_resp_valid);
        end
        if (bus.mem_req_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_ready_after: got %b expected 1", bus.mem_req_ready);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.mem_resp_valid !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_err++; $display("FAIL rst_mid_stray_beats: got %0d expected 0", stray);
        end

        // A write whose data only arrives in the reset cycle must not be committed.
        wait_ready();
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b1;
        bus.mem_req_addr  = 28'h0000011;
        tick();
        bus.mem_req_valid = 1'b0;
        bus.mem_req_rw    = 1'b0;
        n_cmp++;
        if (bus.mem_req_data_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_wr_data_ready: got %b expected 1", bus.mem_req_data_ready);
        end
        reset                  = 1'b1;
        bus.mem_req_data_valid = 1'b1;
        bus.mem_req_data_bits  = {16{8'hFF}};
        bus.mem_req_data_mask  = 16'hFFFF;
        #1;
        n_cmp++;
        if (bus.mem_req_data_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_wr_data_ready_in_reset: got %b expected 0", bus.mem_req_data_ready);
        end
        tick();
        reset = 1'b0;
        idle_inputs();
        read_line(28'h0000010);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got[i] !== 128'(i + 1)) begin
                n_err++; $display("FAIL rst_reread_beat%0d: got %h expected %h", i, got[i], 128'(i + 1));
            end
        end
    endtask

    task automatic test_alias();
        logic [DATA_BITS-1:0] d = 128'hFEEDFACE_CAFEBABE_DEADBEEF_12345678;
        write_beat(28'h0001000, d, 16'hFFFF);
        read_line(28'h0000000);
        n_cmp++;
        if (got[0] !== d) begin
            n_err++; $display("FAIL alias_low: got %h expected %h", got[0], d);
        end
        read_line(28'h0FFF002);
        n_cmp++;
        if (got[0] !== d) begin
            n_err++; $display("FAIL alias_high: got %h expected %h", got[0], d);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_mask();
        test_burst_order();
        test_back_to_back();
        test_reset_mid();
        test_alias();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
